// File: rtl/uart_rx.sv
// uart_rx - oversampling UART receiver.
//
// The asynchronous rx line goes through a two-flop synchronizer. A frame of
// start, data (LSB first), optional parity and stop bits is then deframed
// with a tick counter that runs at OVERSAMPLE clocks per bit. The start bit
// is qualified at its middle, and every later bit is sampled one full bit
// period after that point.
//
// Ports:
//   clk         in   oversampling clock (OVERSAMPLE x baud), rising edge
//   rst_n       in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous to clk
//   data_pkg    out  last received word, held until the next valid
//   valid       out  one-cycle pulse when a frame completes
//   parity_err  out  parity mismatch on the last frame
//   frame_err   out  a stop bit was sampled low on the last frame
//   state_dbg_o out  current FSM state (debug observation)
//
// Handshake: valid is a one-cycle strobe with no ready. data_pkg,
// parity_err and frame_err are only meaningful from the cycle in which
// valid is high, and they stay stable until the next valid pulse.

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ON  = 1,
  parameter int PARITY_ODD = 1,
  parameter int STOP_BIT   = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_pkg,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic [2:0]            state_dbg_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BIT == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic                  stopcnt_q, stopcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  par_exp;
  logic [DATA_WIDTH:0]   shift_in;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // New bits enter at the MSB and move down, so after DATA_WIDTH shifts
  // the first (LSB-first) bit sits at bit 0.
  assign shift_in = {rx_s_q, shift_q};
  assign par_exp  = (PARITY_ODD != 0) ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bitcnt_d     = bitcnt_q;
    stopcnt_d    = stopcnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid start bit: still high means a glitch shorter than half a bit.
        if (cnt_q == CNT_MID) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_in[DATA_WIDTH:1];
          if (bitcnt_q == BIT_LAST) state_d = (PARITY_ON != 0) ? S_PARITY : S_STOP;
          else bitcnt_d = bitcnt_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s_q != par_exp) perr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          if (stopcnt_q == STOP_LAST) begin
            data_d       = shift_q;
            valid_d      = 1'b1;
            parity_err_d = (PARITY_ON != 0) && perr_q;
            frame_err_d  = ferr_q | ~rx_s_q;
            // A low line after an error (e.g. a break) must not retrigger START.
            state_d = (ferr_q | ~rx_s_q | perr_q) ? S_WAIT_HIGH : S_IDLE;
          end else begin
            stopcnt_d = stopcnt_q + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every state starts with fresh counters.
    if (state_d != state_q) begin
      cnt_d     = '0;
      bitcnt_d  = '0;
      stopcnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      stopcnt_q    <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      stopcnt_q    <= stopcnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_pkg    = data_q;
  assign valid       = valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed bench for uart_rx.
// u_dut uses the default 8-O-1 framing; u_dut_b2b uses 8-N-2 for the
// back-to-back frame case. Both run at 16 clocks per bit.

module tb_uart_rx;

  localparam int N = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data_pkg, data_pkg2;
  logic       valid, valid2;
  logic       parity_err, parity_err2;
  logic       frame_err, frame_err2;
  logic [2:0] state1, state2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitors: count valid-high cycles and remember when / what arrived.
  int vcnt1 = 0;
  int last_vcyc1 = -1;
  int vcyc2_q[$];
  logic [7:0] vdat2_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.DATA_WIDTH(8), .PARITY_ON(1), .PARITY_ODD(1), .STOP_BIT(1), .OVERSAMPLE(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_pkg(data_pkg), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .state_dbg_o(state1)
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY_ON(0), .PARITY_ODD(1), .STOP_BIT(2), .OVERSAMPLE(N)) u_dut_b2b (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .data_pkg(data_pkg2), .valid(valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .state_dbg_o(state2)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt1 = vcnt1 + 1;
      last_vcyc1 = cyc;
    end
    if (valid2) begin
      vcyc2_q.push_back(cyc);
      vdat2_q.push_back(data_pkg2);
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish, observed=running required=done");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 8-O-1 frame on rx. Line is left at the stop-bit level. k = first edge
  // after the start-bit falling edge.
  task automatic send1(input logic [7:0] d, input logic pbit, input logic stopv, output int k);
    k = cyc + 1;
    exp_q.push_back(d);
    rx = 1'b0; tick(N);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; tick(N);
    end
    rx = pbit; tick(N);
    rx = stopv; tick(N);
  endtask

  // 8-N-2 frame on rx2.
  task automatic send2(input logic [7:0] d, output int k);
    k = cyc + 1;
    exp_q.push_back(d);
    rx2 = 1'b0; tick(N);
    for (int i = 0; i < 8; i++) begin
      rx2 = d[i]; tick(N);
    end
    rx2 = 1'b1; tick(2 * N);
  endtask

  int k, v0;
  int kb[3];
  logic [7:0] e;

  initial begin
    // ---------------- reset ----------------
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_data", data_pkg, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_state", state1, ST_IDLE);
    check("rst_state_b2b", state2, ST_IDLE);

    // ---------------- basic frame 0xA5, odd parity bit 1 ----------------
    v0 = vcnt1;
    send1(8'hA5, 1'b1, 1'b1, k);
    tick(20);
    check("basic_pulses", vcnt1 - v0, 1);
    check("basic_latency", last_vcyc1, k + 170);
    e = exp_q.pop_front();
    check("basic_data", data_pkg, e);
    check("basic_perr", parity_err, 1'b0);
    check("basic_ferr", frame_err, 1'b0);

    // ---------------- parity error 0x3C with parity bit 0 ----------------
    v0 = vcnt1;
    send1(8'h3C, 1'b0, 1'b1, k);
    tick(20);
    check("perr_pulses", vcnt1 - v0, 1);
    e = exp_q.pop_front();
    check("perr_data", data_pkg, e);
    check("perr_flag", parity_err, 1'b1);
    check("perr_ferr", frame_err, 1'b0);
    send1(8'h3C, 1'b1, 1'b1, k);
    tick(20);
    check("perr_clear_latency", last_vcyc1, k + 170);
    e = exp_q.pop_front();
    check("perr_clear_data", data_pkg, e);
    check("perr_clear_flag", parity_err, 1'b0);

    // ---------------- frame error then 40-bit break ----------------
    v0 = vcnt1;
    send1(8'h55, 1'b1, 1'b0, k);
    rx = 1'b0;
    tick(40 * N);
    check("break_pulses", vcnt1 - v0, 1);
    check("break_latency", last_vcyc1, k + 170);
    e = exp_q.pop_front();
    check("break_data", data_pkg, e);
    check("break_ferr", frame_err, 1'b1);
    check("break_state", state1, ST_WAIT);
    rx = 1'b1;
    tick(32);
    check("break_release_pulses", vcnt1 - v0, 1);
    check("break_release_state", state1, ST_IDLE);
    send1(8'h12, 1'b1, 1'b1, k);
    tick(20);
    check("after_break_pulses", vcnt1 - v0, 2);
    e = exp_q.pop_front();
    check("after_break_data", data_pkg, e);
    check("after_break_perr", parity_err, 1'b0);
    check("after_break_ferr", frame_err, 1'b0);

    // ---------------- glitch rejection ----------------
    v0 = vcnt1;
    rx = 1'b0; tick(6);
    rx = 1'b1; tick(30);
    check("glitch_pulses", vcnt1 - v0, 0);
    check("glitch_state", state1, ST_IDLE);
    // N/2+3 low cycles is a real start bit; the high line then reads 0xFF,
    // odd parity bit 1, stop 1.
    rx = 1'b0; tick(N / 2 + 3);
    rx = 1'b1; tick(2);
    check("long_pulse_state", state1, ST_DATA);
    exp_q.push_back(8'hFF);
    tick(200);
    check("long_pulse_pulses", vcnt1 - v0, 1);
    e = exp_q.pop_front();
    check("long_pulse_data", data_pkg, e);
    check("long_pulse_perr", parity_err, 1'b0);
    check("long_pulse_ferr", frame_err, 1'b0);

    // ---------------- back-to-back 8-N-2 frames ----------------
    vcyc2_q.delete();
    vdat2_q.delete();
    send2(8'h00, kb[0]);
    send2(8'hFF, kb[1]);
    send2(8'h81, kb[2]);
    tick(20);
    check("b2b_count", vcyc2_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      if (vcyc2_q.size() > 0) begin
        check("b2b_latency", vcyc2_q.pop_front(), kb[0] + 170 + 176 * i);
        check("b2b_data", vdat2_q.pop_front(), e);
      end
    end
    check("b2b_perr", parity_err2, 1'b0);
    check("b2b_ferr", frame_err2, 1'b0);

    // ---------------- reset mid-frame (DATA bit 4 of 0x5A) ----------------
    v0 = vcnt1;
    rx = 1'b0; tick(N);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 1 || i == 3) ? 1'b1 : 1'b0; tick(N);
    end
    rx = 1'b1; tick(N / 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", data_pkg, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_state", state1, ST_IDLE);
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    send1(8'h5A, 1'b1, 1'b1, k);
    tick(20);
    check("midrst_pulses", vcnt1 - v0, 1);
    check("midrst_latency", last_vcyc1, k + 170);
    e = exp_q.pop_front();
    check("midrst_rx_data", data_pkg, e);
    check("midrst_rx_perr", parity_err, 1'b0);
    check("midrst_rx_ferr", frame_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
